varredura_mux_4x1: RTL and testbench
====================================

# varredura_mux_4x1

Round-robin scan controller for the 4-to-1 N-bit multiplexer stage. It drives the mux `SEL` lines and holds each channel for a programmable dwell time. At the end of each dwell it captures the mux output into a registered sample with a one-cycle valid strobe, and flags the end of each four-channel sweep. It sits around the mux: upstream on `SEL`, downstream on `MUX_OUT`.

## Interface
- `BITS`, 4: width of mux data path (≥1).
- `DWELL`, 3: cycles `SEL` is held per channel before sampling (≥1).
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserted (0) clears all state immediately.
- `iniciar` input 1: start request, sampled on rising edge.
- `abortar` input 1: synchronous abort of a sweep in progress.
- `continuo` input 1: restart the sweep automatically after channel 3 (see Configuration).
- `MUX_OUT` input BITS: data from the mux output.
- `SEL` output 2: channel select to the mux.
- `dado` output BITS: last captured sample.
- `canal` output 2: channel index of `dado`.
- `amostra_valida` output 1: one-cycle pulse, `dado`/`canal` updated this cycle.
- `pronto` output 1: one-cycle pulse, sweep completed.
- `ocupado` output 1: high while a sweep is active.

## Operation
- All outputs are registered. Reset values: `SEL`=00, `dado`=0, `canal`=00, `amostra_valida`=0, `pronto`=0, `ocupado`=0, FSM=INICIAL, dwell counter=0.
- FSM states: INICIAL, ESPERA, FIM.
- INICIAL:
  - `iniciar`=1 → ESPERA, `SEL`=00, counter=0, `ocupado`=1.
  - Otherwise stay; `SEL` holds 00.
- ESPERA:
  - While counter<DWELL-1, the counter increments each cycle.
  - When counter==DWELL-1, on the same edge: `dado`←`MUX_OUT`, `canal`←`SEL`, `amostra_valida`←1, counter←0.
  - If `SEL`≠11: `SEL`←`SEL`+1 and stay in ESPERA.
  - If `SEL`==11: `pronto`←1 and → FIM.
- FIM (one cycle):
  - Effective `continuo`=1 → ESPERA with `SEL`=00, counter=0, `ocupado` stays 1.
  - Otherwise → INICIAL with `ocupado`=0.
- `amostra_valida` and `pronto` are cleared the cycle after they are set.
- `iniciar` is ignored while `ocupado`=1.
- `abortar`=1 in ESPERA or FIM → INICIAL, `SEL`=00, counter=0, `ocupado`=0. No `amostra_valida` or `pronto` is produced on that edge.
  - `abortar` has priority over a coincident sample.
  - `dado`/`canal` keep their last values.
- `abortar` in INICIAL has no effect. `abortar` and `iniciar` asserted together in INICIAL → start wins.
- Counter width: $clog2(DWELL)+1 bits. DWELL=1 gives a sample on every cycle.
- Reset asserted mid-sweep: every output returns to its reset value asynchronously. Nothing resumes after release.

## Timing
- Edge k samples `iniciar`=1 → after edge k: `SEL`=00, `ocupado`=1.
- The first `amostra_valida` is high after edge k+DWELL, with `canal`=00.
- Channel n sample appears after edge k+(n+1)·DWELL. `pronto` is high in the same cycle as the channel-3 `amostra_valida`.
- FIM adds one idle cycle.
  - Continuous mode: the next channel-0 sample is at edge k+5·DWELL+1.
  - Single mode: `ocupado` falls after edge k+4·DWELL+1.
- `MUX_OUT` must be valid at the sampling edge. The mux is combinational, and `SEL` has been stable for DWELL cycles by then.

## Configuration
- Macro `VARREDURA_CONTINUO_EN`.
- Defined: the `continuo` input is honoured in FIM.
- Undefined: `continuo` is ignored (treated as 0). Every sweep is single-shot and returns to INICIAL. The port remains present in both builds.

## Test plan
- Reset, then BITS=4, DWELL=3, mux inputs D0..D3 = 1,2,3,4, `iniciar` pulse:
  - Four `amostra_valida` pulses, 3 cycles apart.
  - (`canal`,`dado`) = (0,1),(1,2),(2,3),(3,4).
  - `pronto` coincides with (3,4); `ocupado` falls 1 cycle later.
- DWELL=1, continuous build, `continuo`=1:
  - Samples every cycle for channels 0–3, then a 1-cycle gap, then channel 0 again.
  - `SEL` wraps 11→00.
  - `pronto` pulses once per sweep.
- Assert `abortar` on the exact cycle channel 2 would be sampled:
  - No `amostra_valida`.
  - `SEL`=00, `ocupado`=0.
  - `dado`=2 and `canal`=1 retained.
- Pulse `iniciar` mid-sweep: ignored. Sweep timing and sample order are unchanged.
- Drive `reset` low at an asynchronous point mid-ESPERA: all outputs are at reset values before the next clock edge. After release with no `iniciar`, the block stays idle.
- Build without `VARREDURA_CONTINUO_EN`, `continuo`=1: a single sweep only, then `ocupado`=0.

Source files
------------

// File: rtl/varredura_mux_4x1.sv
// varredura_mux_4x1 -- round-robin scan controller for a 4-to-1 mux stage.
//
// Drives the mux select lines through channels 0..3. Each channel is held
// for DWELL cycles. On the last dwell cycle the mux output is captured into
// `dado`/`canal` with a one-cycle `amostra_valida` strobe. `pronto` pulses
// with the channel-3 sample, and one idle cycle (FIM) follows each sweep.
//
// Parameters:
//   BITS  - mux data width (>= 1)
//   DWELL - cycles SEL is held per channel before sampling (>= 1)
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   iniciar        in   start request (ignored while ocupado)
//   abortar        in   synchronous abort of an active sweep
//   continuo       in   auto-restart after channel 3 (continuous build only)
//   MUX_OUT        in   [BITS] data from the mux
//   SEL            out  [2] channel select to the mux
//   dado           out  [BITS] last captured sample
//   canal          out  [2] channel index of dado
//   amostra_valida out  one-cycle pulse when dado/canal update
//   pronto         out  one-cycle pulse at the end of a sweep
//   ocupado        out  high while a sweep is active
//
// Build option:
//   VARREDURA_CONTINUO_EN - when defined, `continuo` is honoured in FIM.
//   When undefined, it is treated as 0 and every sweep is single-shot.
//   The `continuo` port exists in both builds.

module varredura_mux_4x1 #(
   parameter int BITS  = 4,
   parameter int DWELL = 3
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            iniciar,
   input  logic            abortar,
   input  logic            continuo,
   input  logic [BITS-1:0] MUX_OUT,
   output logic [1:0]      SEL,
   output logic [BITS-1:0] dado,
   output logic [1:0]      canal,
   output logic            amostra_valida,
   output logic            pronto,
   output logic            ocupado
);

   localparam int            CW       = $clog2(DWELL) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {INICIAL, ESPERA, FIM} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [1:0]      sel_nx;
   logic [BITS-1:0] dado_nx;
   logic [1:0]      canal_nx;
   logic            av_nx, pronto_nx, ocupado_nx;
   logic            cont_ef;

`ifdef VARREDURA_CONTINUO_EN
   assign cont_ef = continuo;
`else
   // Single-shot build: the port is kept but has no effect.
   logic unused_continuo;
   assign unused_continuo = continuo;
   assign cont_ef         = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= INICIAL;
         cnt            <= '0;
         SEL            <= 2'b00;
         dado           <= '0;
         canal          <= 2'b00;
         amostra_valida <= 1'b0;
         pronto         <= 1'b0;
         ocupado        <= 1'b0;
      end else begin
         state          <= state_nx;
         cnt            <= cnt_nx;
         SEL            <= sel_nx;
         dado           <= dado_nx;
         canal          <= canal_nx;
         amostra_valida <= av_nx;
         pronto         <= pronto_nx;
         ocupado        <= ocupado_nx;
      end
   end

   always_comb begin
      // Strobes default low so they last exactly one cycle; data holds.
      state_nx   = state;
      cnt_nx     = cnt;
      sel_nx     = SEL;
      dado_nx    = dado;
      canal_nx   = canal;
      av_nx      = 1'b0;
      pronto_nx  = 1'b0;
      ocupado_nx = ocupado;

      case (state)
         INICIAL: begin
            // abortar is meaningless here, so a coincident start wins.
            sel_nx = 2'b00;
            cnt_nx = '0;
            if (iniciar) begin
               state_nx   = ESPERA;
               ocupado_nx = 1'b1;
            end
         end

         ESPERA: begin
            if (abortar) begin
               // Abort beats a coincident sample; dado/canal keep old values.
               state_nx   = INICIAL;
               sel_nx     = 2'b00;
               cnt_nx     = '0;
               ocupado_nx = 1'b0;
            end else if (cnt == CNT_LAST) begin
               dado_nx  = MUX_OUT;
               canal_nx = SEL;
               av_nx    = 1'b1;
               cnt_nx   = '0;
               if (SEL != 2'b11) begin
                  sel_nx = SEL + 2'd1;
               end else begin
                  // SEL stays at 11 through FIM; cleared on leaving FIM.
                  pronto_nx = 1'b1;
                  state_nx  = FIM;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end

         FIM: begin
            sel_nx = 2'b00;
            cnt_nx = '0;
            if (!abortar && cont_ef) begin
               state_nx = ESPERA;
            end else begin
               state_nx   = INICIAL;
               ocupado_nx = 1'b0;
            end
         end

         default: begin
            state_nx   = INICIAL;
            sel_nx     = 2'b00;
            cnt_nx     = '0;
            ocupado_nx = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_varredura_mux_4x1.sv
// Self-checking bench for varredura_mux_4x1.
// dut 0: DWELL=3 (main sweeps, abort, reset). dut 1: DWELL=1 (continuo).
// Expected samples go to a per-DUT queue when a sweep is started and are
// popped when the cycle they are due arrives.
module tb_varredura_mux_4x1;
   localparam int BITS = 4;

   typedef struct {
      int              cyc;
      logic [1:0]      canal;
      logic [BITS-1:0] dado;
      logic            pronto;
   } exp_t;

   typedef struct {
      logic [3:0][BITS-1:0] din;
      int                   glitch;   // cycle offset of a stray iniciar, 0 = none
      logic                 ab;       // abortar together with the start pulse
      logic [3:0][BITS-1:0] ex;
   } vec_t;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [1:0]      iniciar, abortar, continuo;
   logic [BITS-1:0] din   [2][4];
   logic [BITS-1:0] mux_out [2];
   logic [1:0]      sel   [2];
   logic [BITS-1:0] dado  [2];
   logic [1:0]      canal [2];
   logic            av    [2];
   logic            pronto [2];
   logic            ocupado [2];

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clock = ~clock;

   assign mux_out[0] = din[0][sel[0]];
   assign mux_out[1] = din[1][sel[1]];

   varredura_mux_4x1 #(.BITS(BITS), .DWELL(3)) dut0 (
      .clock(clock), .reset(reset), .iniciar(iniciar[0]), .abortar(abortar[0]),
      .continuo(continuo[0]), .MUX_OUT(mux_out[0]), .SEL(sel[0]), .dado(dado[0]),
      .canal(canal[0]), .amostra_valida(av[0]), .pronto(pronto[0]), .ocupado(ocupado[0]));

   varredura_mux_4x1 #(.BITS(BITS), .DWELL(1)) dut1 (
      .clock(clock), .reset(reset), .iniciar(iniciar[1]), .abortar(abortar[1]),
      .continuo(continuo[1]), .MUX_OUT(mux_out[1]), .SEL(sel[1]), .dado(dado[1]),
      .canal(canal[1]), .amostra_valida(av[1]), .pronto(pronto[1]), .ocupado(ocupado[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic sb_step(input int i);
      exp_t e;
      logic have;
      have = 1'b0;
      if (i == 0) begin
         if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); have = 1'b1; end
      end else begin
         if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
      end
      if (have) begin
         chk($sformatf("dut%0d valid ch%0d", i, e.canal), av[i], 1);
         if (av[i]) begin
            chk($sformatf("dut%0d canal", i), canal[i], e.canal);
            chk($sformatf("dut%0d dado ch%0d", i, e.canal), dado[i], e.dado);
            chk($sformatf("dut%0d pronto ch%0d", i, e.canal), pronto[i], e.pronto);
         end
      end else begin
         if (av[i])     chk($sformatf("dut%0d unexpected sample", i), av[i], 0);
         if (pronto[i]) chk($sformatf("dut%0d unexpected pronto", i), pronto[i], 0);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      sb_step(0);
      sb_step(1);
   endtask

   // Start a sweep on dut i and queue its expected samples.
   task automatic start(input int i, input int dw, input logic [3:0][BITS-1:0] ex,
                        input int sweeps, output int k);
      exp_t e;
      k = cyc + 1;
      for (int s = 0; s < sweeps; s++)
         for (int n = 0; n < 4; n++) begin
            e.cyc    = k + s * (4 * dw + 1) + (n + 1) * dw;
            e.canal  = 2'(n);
            e.dado   = ex[n];
            e.pronto = (n == 3);
            if (i == 0) q0.push_back(e); else q1.push_back(e);
         end
      iniciar[i] = 1'b1;
      tick();
      iniciar[i] = 1'b0;
      chk($sformatf("dut%0d SEL after start", i), sel[i], 0);
      chk($sformatf("dut%0d ocupado after start", i), ocupado[i], 1);
   endtask

   initial begin
      vec_t vt[4];
      int   k;
      int   sweeps;

      vt[0] = '{din: {4'h4, 4'h3, 4'h2, 4'h1}, glitch: 0, ab: 1'b0, ex: {4'h4, 4'h3, 4'h2, 4'h1}};
      vt[1] = '{din: {4'h5, 4'hA, 4'h0, 4'hF}, glitch: 0, ab: 1'b1, ex: {4'h5, 4'hA, 4'h0, 4'hF}};
      vt[2] = '{din: {4'h0, 4'h0, 4'h0, 4'h0}, glitch: 4, ab: 1'b0, ex: {4'h0, 4'h0, 4'h0, 4'h0}};
      vt[3] = '{din: {4'h5, 4'h6, 4'h7, 4'h8}, glitch: 8, ab: 1'b0, ex: {4'h5, 4'h6, 4'h7, 4'h8}};

      iniciar  = '0;
      abortar  = '0;
      continuo = '0;
      for (int n = 0; n < 4; n++) begin din[0][n] = '0; din[1][n] = '0; end

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("reset SEL", sel[0], 0);
      chk("reset dado", dado[0], 0);
      chk("reset canal", canal[0], 0);
      chk("reset valid", av[0], 0);
      chk("reset pronto", pronto[0], 0);
      chk("reset ocupado", ocupado[0], 0);
      #3 reset = 1'b1;
      repeat (2) tick();

      // Table-driven single sweeps on the DWELL=3 instance
      for (int v = 0; v < 4; v++) begin
         for (int n = 0; n < 4; n++) din[0][n] = vt[v].din[n];
         abortar[0] = vt[v].ab;
         start(0, 3, vt[v].ex, 1, k);
         abortar[0] = 1'b0;
         while (cyc < k + 12) begin
            iniciar[0] = (vt[v].glitch != 0 && cyc == k + vt[v].glitch);
            tick();
         end
         iniciar[0] = 1'b0;
         chk($sformatf("vec%0d ocupado with pronto", v), ocupado[0], 1);
         tick();
         chk($sformatf("vec%0d ocupado falls", v), ocupado[0], 0);
         chk($sformatf("vec%0d SEL idle", v), sel[0], 0);
         chk($sformatf("vec%0d all samples seen", v), q0.size(), 0);
         repeat (2) tick();
      end

      // Abort on the edge channel 2 would be sampled
      for (int n = 0; n < 4; n++) din[0][n] = 4'(n + 1);
      start(0, 3, {4'h4, 4'h3, 4'h2, 4'h1}, 1, k);
      void'(q0.pop_back());
      void'(q0.pop_back());
      while (cyc < k + 8) tick();
      abortar[0] = 1'b1;
      tick();
      abortar[0] = 1'b0;
      chk("abort no valid", av[0], 0);
      chk("abort SEL", sel[0], 0);
      chk("abort ocupado", ocupado[0], 0);
      chk("abort dado kept", dado[0], 2);
      chk("abort canal kept", canal[0], 1);
      repeat (4) tick();
      chk("abort stays idle", ocupado[0], 0);

      // DWELL=1 with continuo=1
`ifdef VARREDURA_CONTINUO_EN
      sweeps = 2;
`else
      sweeps = 1;
`endif
      for (int n = 0; n < 4; n++) din[1][n] = 4'(n + 9);
      continuo[1] = 1'b1;
      start(1, 1, {4'hC, 4'hB, 4'hA, 4'h9}, sweeps, k);
      while (cyc < k + 4) tick();
      chk("dw1 SEL at ch3", sel[1], 3);
      tick();
      chk("dw1 SEL wraps", sel[1], 0);
      if (sweeps == 2) begin
         chk("dw1 ocupado held", ocupado[1], 1);
         tick();
         continuo[1] = 1'b0;
         while (cyc < k + 10) tick();
         chk("dw1 ocupado end of 2nd sweep", ocupado[1], 0);
      end else begin
         chk("dw1 single-shot ocupado", ocupado[1], 0);
      end
      repeat (6) tick();
      continuo[1] = 1'b0;
      chk("dw1 no more samples", q1.size(), 0);
      chk("dw1 idle", ocupado[1], 0);

      // Asynchronous reset mid-ESPERA
      for (int n = 0; n < 4; n++) din[0][n] = 4'(n + 1);
      start(0, 3, {4'h4, 4'h3, 4'h2, 4'h1}, 1, k);
      while (cyc < k + 5) tick();
      #3 reset = 1'b0;
      #1;
      q0.delete();
      chk("async rst SEL", sel[0], 0);
      chk("async rst dado", dado[0], 0);
      chk("async rst canal", canal[0], 0);
      chk("async rst valid", av[0], 0);
      chk("async rst pronto", pronto[0], 0);
      chk("async rst ocupado", ocupado[0], 0);
      #2 reset = 1'b1;
      repeat (8) tick();
      chk("post-rst idle ocupado", ocupado[0], 0);
      chk("post-rst idle SEL", sel[0], 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
